// File: rtl/fifo_arbiter_if.sv
// Byte-wide device FIFO bus: read strobe with rx flags/data, write strobe with tx flags/data.
// 'controller' drives the strobes; 'fifo' presents the flags and read data.
interface fifo_bus;
  logic       rx_read;
  logic       rx_empty;
  logic       rx_almost_empty;
  logic [7:0] rx_rdata;
  logic       tx_write;
  logic       tx_full;
  logic       tx_almost_full;
  logic [7:0] tx_wdata;

  modport controller (
    output rx_read, tx_write, tx_wdata,
    input  rx_empty, rx_almost_empty, rx_rdata, tx_full, tx_almost_full
  );

  modport fifo (
    input  rx_read, tx_write, tx_wdata,
    output rx_empty, rx_almost_empty, rx_rdata, tx_full, tx_almost_full
  );
endinterface

// File: rtl/fifo_arbiter.sv
// Grants one device FIFO to either the configuration or the DMA client, with round-robin
// arbitration and burst-limited preemption when both clients compete.
module fifo_arbiter #(
  parameter int unsigned BURST_MAX = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  fifo_bus.controller dev_bus,
  fifo_bus.fifo       cfg_bus,
  fifo_bus.fifo       dma_bus,
  input  logic        cfg_req,
  input  logic        dma_req,
  output logic        cfg_grant,
  output logic        dma_grant
);

  localparam int unsigned CntW = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {StIdle, StCfg, StDma} state_e;

  state_e          state_q, state_d;
  logic            last_dma_q, last_dma_d;
  logic [CntW-1:0] burst_cnt_q, burst_cnt_d;

  logic       cfg_own, dma_own;
  logic       owner_rx_read, owner_tx_write;
  logic [7:0] owner_tx_wdata;
  logic       owner_req, other_req;
  logic       rx_read_gated, tx_write_gated;
  logic       accepted, at_max;

  assign cfg_own = (state_q == StCfg);
  assign dma_own = (state_q == StDma);

  always_comb begin
    owner_rx_read  = 1'b0;
    owner_tx_write = 1'b0;
    owner_tx_wdata = '0;
    owner_req      = 1'b0;
    other_req      = 1'b0;
    unique case (state_q)
      StCfg: begin
        owner_rx_read  = cfg_bus.rx_read;
        owner_tx_write = cfg_bus.tx_write;
        owner_tx_wdata = cfg_bus.tx_wdata;
        owner_req      = cfg_req;
        other_req      = dma_req;
      end
      StDma: begin
        owner_rx_read  = dma_bus.rx_read;
        owner_tx_write = dma_bus.tx_write;
        owner_tx_wdata = dma_bus.tx_wdata;
        owner_req      = dma_req;
        other_req      = cfg_req;
      end
      default: ;
    endcase
  end

  // Strobes are gated by the registered grant and the true device flow-control flags.
  assign rx_read_gated  = owner_rx_read & ~dev_bus.rx_empty;
  assign tx_write_gated = owner_tx_write & ~dev_bus.tx_full;
  assign accepted       = rx_read_gated | tx_write_gated;

  assign dev_bus.rx_read  = rx_read_gated;
  assign dev_bus.tx_write = tx_write_gated;
  assign dev_bus.tx_wdata = owner_tx_wdata;

  // Non-owners see an empty, full FIFO so they never attempt a transfer.
  assign cfg_bus.rx_empty        = cfg_own ? dev_bus.rx_empty        : 1'b1;
  assign cfg_bus.rx_almost_empty = cfg_own ? dev_bus.rx_almost_empty : 1'b1;
  assign cfg_bus.tx_full         = cfg_own ? dev_bus.tx_full         : 1'b1;
  assign cfg_bus.tx_almost_full  = cfg_own ? dev_bus.tx_almost_full  : 1'b1;
  assign cfg_bus.rx_rdata        = dev_bus.rx_rdata;

  assign dma_bus.rx_empty        = dma_own ? dev_bus.rx_empty        : 1'b1;
  assign dma_bus.rx_almost_empty = dma_own ? dev_bus.rx_almost_empty : 1'b1;
  assign dma_bus.tx_full         = dma_own ? dev_bus.tx_full         : 1'b1;
  assign dma_bus.tx_almost_full  = dma_own ? dev_bus.tx_almost_full  : 1'b1;
  assign dma_bus.rx_rdata        = dev_bus.rx_rdata;

  assign at_max = (burst_cnt_q == CntW'(BURST_MAX));

  always_comb begin
    state_d    = state_q;
    last_dma_d = last_dma_q;
    unique case (state_q)
      StIdle: begin
        if (cfg_req && dma_req) begin
          // Contested: the client that did not own the bus last wins.
          if (last_dma_q) begin
            state_d    = StCfg;
            last_dma_d = 1'b0;
          end else begin
            state_d    = StDma;
            last_dma_d = 1'b1;
          end
        end else if (cfg_req) begin
          state_d    = StCfg;
          last_dma_d = 1'b0;
        end else if (dma_req) begin
          state_d    = StDma;
          last_dma_d = 1'b1;
        end
      end
      StCfg, StDma: begin
        if (!owner_req || (at_max && other_req)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (state_d == StIdle) begin
      burst_cnt_d = '0;
    end else if (accepted && !at_max) begin
      burst_cnt_d = burst_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      last_dma_q  <= 1'b1;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      last_dma_q  <= last_dma_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign cfg_grant = cfg_own;
  assign dma_grant = dma_own;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter (BURST_MAX = 4): expected device strobes and grant
// transitions are queued by the stimulus and checked by independent monitors.
module tb_fifo_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic cfg_req = 1'b0;
  logic dma_req = 1'b0;
  logic cfg_grant, dma_grant;

  fifo_bus dev_if ();
  fifo_bus cfg_if ();
  fifo_bus dma_if ();

  int total = 0;
  int bad = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [1:0] g_q[$];
  logic [1:0] gprev = 2'b00;

  fifo_arbiter #(.BURST_MAX(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .dev_bus   (dev_if),
    .cfg_bus   (cfg_if),
    .dma_bus   (dma_if),
    .cfg_req   (cfg_req),
    .dma_req   (dma_req),
    .cfg_grant (cfg_grant),
    .dma_grant (dma_grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe scoreboard: every accepted device strobe must match a queued expectation.
  always @(negedge clk) begin
    if (dev_if.rx_read === 1'b1) begin
      if (rx_q.size() == 0) chk("rx_unexpected", 32'd1, 32'd0);
      else begin
        logic [7:0] e;
        e = rx_q.pop_front();
        chk("rx_rdata_dma", {24'd0, dma_if.rx_rdata}, {24'd0, e});
        chk("rx_rdata_cfg", {24'd0, cfg_if.rx_rdata}, {24'd0, e});
      end
    end
    if (dev_if.tx_write === 1'b1) begin
      if (tx_q.size() == 0) chk("tx_unexpected", 32'd1, 32'd0);
      else begin
        logic [7:0] e;
        e = tx_q.pop_front();
        chk("tx_wdata", {24'd0, dev_if.tx_wdata}, {24'd0, e});
      end
    end
  end

  // Grant monitor: exclusivity every cycle, and each change must match the queued sequence.
  always @(negedge clk) begin
    logic [1:0] g;
    g = {cfg_grant, dma_grant};
    chk("grant_mutex", {31'd0, cfg_grant & dma_grant}, 32'd0);
    if (g !== gprev) begin
      if (g_q.size() == 0) chk("grant_unexpected", {30'd0, g}, {30'd0, gprev});
      else chk("grant_seq", {30'd0, g}, {30'd0, g_q.pop_front()});
    end
    gprev = g;
  end

  task automatic clr_clients();
    cfg_if.rx_read = 1'b0; cfg_if.tx_write = 1'b0; cfg_if.tx_wdata = 8'h00;
    dma_if.rx_read = 1'b0; dma_if.tx_write = 1'b0; dma_if.tx_wdata = 8'h00;
  endtask

  initial begin
    clr_clients();
    dev_if.rx_empty = 1'b0; dev_if.rx_almost_empty = 1'b0; dev_if.rx_rdata = 8'h3C;
    dev_if.tx_full  = 1'b0; dev_if.tx_almost_full  = 1'b0;
    #1 reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Reset state
    chk("rst_cfg_grant", {31'd0, cfg_grant}, 32'd0);
    chk("rst_dma_grant", {31'd0, dma_grant}, 32'd0);
    chk("rst_cfg_rx_empty", {31'd0, cfg_if.rx_empty}, 32'd1);
    chk("rst_dma_tx_full", {31'd0, dma_if.tx_full}, 32'd1);

    // Single owner with three writes
    cfg_req = 1'b1; g_q.push_back(2'b10);
    tick();
    chk("t1_cfg_grant", {31'd0, cfg_grant}, 32'd1);
    chk("t1_cfg_almost_full", {31'd0, cfg_if.tx_almost_full}, 32'd0);
    chk("t1_cfg_almost_empty", {31'd0, cfg_if.rx_almost_empty}, 32'd0);
    chk("t1_dma_almost_full", {31'd0, dma_if.tx_almost_full}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cfg_if.tx_write = 1'b1; cfg_if.tx_wdata = 8'hA1 + 8'(i);
      tx_q.push_back(8'hA1 + 8'(i));
      tick();
    end
    clr_clients();
    cfg_req = 1'b0; g_q.push_back(2'b00);
    chk("t1_grant_same_cycle", {31'd0, cfg_grant}, 32'd1);
    tick();
    chk("t1_release", {31'd0, cfg_grant}, 32'd0);

    // Contention after reset: CFG first, then DMA, then CFG again
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    cfg_req = 1'b1; dma_req = 1'b1; g_q.push_back(2'b10);
    tick();
    chk("t2_cfg_first", {30'd0, cfg_grant, dma_grant}, 32'd2);
    tick();
    cfg_req = 1'b0; g_q.push_back(2'b00);
    tick();
    chk("t2_idle_gap", {30'd0, cfg_grant, dma_grant}, 32'd0);
    g_q.push_back(2'b01);
    tick();
    chk("t2_dma_next", {30'd0, cfg_grant, dma_grant}, 32'd1);
    dma_req = 1'b0; g_q.push_back(2'b00);
    tick();
    cfg_req = 1'b1; dma_req = 1'b1; g_q.push_back(2'b10);
    tick();
    chk("t2_rr_cfg", {30'd0, cfg_grant, dma_grant}, 32'd2);
    cfg_req = 1'b0; dma_req = 1'b0; g_q.push_back(2'b00);
    tick();

    // Preemption: DMA owns, CFG contends, 4 accepted reads
    dma_req = 1'b1; g_q.push_back(2'b01);
    tick();
    chk("t3_dma_grant", {31'd0, dma_grant}, 32'd1);
    cfg_req = 1'b1;
    dma_if.rx_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dev_if.rx_rdata = 8'h10 + 8'(i); rx_q.push_back(8'h10 + 8'(i));
      tick();
    end
    chk("t3_grant_after_max", {31'd0, dma_grant}, 32'd1);
    dev_if.rx_rdata = 8'h20; rx_q.push_back(8'h20);
    g_q.push_back(2'b00);
    tick();
    chk("t3_preempted", {31'd0, dma_grant}, 32'd0);
    chk("t3_dma_rx_empty", {31'd0, dma_if.rx_empty}, 32'd1);
    chk("t3_dev_rx_read_off", {31'd0, dev_if.rx_read}, 32'd0);
    g_q.push_back(2'b10);
    tick();
    chk("t3_cfg_grant", {31'd0, cfg_grant}, 32'd1);

    // Non-owner isolation: CFG owns, DMA strobes with 0x55
    dma_req = 1'b0;
    dma_if.rx_read = 1'b1; dma_if.tx_write = 1'b1; dma_if.tx_wdata = 8'h55;
    cfg_if.rx_read = 1'b1; cfg_if.tx_write = 1'b1; cfg_if.tx_wdata = 8'hC3;
    dev_if.rx_rdata = 8'h9A; rx_q.push_back(8'h9A); tx_q.push_back(8'hC3);
    #1;
    chk("t4_dev_wdata", {24'd0, dev_if.tx_wdata}, 32'hC3);
    chk("t4_dma_rx_empty", {31'd0, dma_if.rx_empty}, 32'd1);
    chk("t4_dma_tx_full", {31'd0, dma_if.tx_full}, 32'd1);
    tick();
    clr_clients();

    // Flow gating: no acceptance, no count, no preemption
    dev_if.rx_empty = 1'b1; dev_if.tx_full = 1'b1; dma_req = 1'b1;
    cfg_if.rx_read = 1'b1; cfg_if.tx_write = 1'b1; cfg_if.tx_wdata = 8'hEE;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_hold_grant", {30'd0, cfg_grant, dma_grant}, 32'd2);
      chk("t5_gated", {30'd0, dev_if.rx_read, dev_if.tx_write}, 32'd0);
    end
    // Count is 1; a dual-strobe cycle counts once, so three more cycles reach the limit.
    dev_if.rx_empty = 1'b0; dev_if.tx_full = 1'b0;
    dev_if.rx_rdata = 8'h6B; rx_q.push_back(8'h6B);
    cfg_if.tx_wdata = 8'hD1; tx_q.push_back(8'hD1);
    tick();
    cfg_if.rx_read = 1'b0;
    cfg_if.tx_wdata = 8'hD2; tx_q.push_back(8'hD2);
    tick();
    cfg_if.tx_wdata = 8'hD3; tx_q.push_back(8'hD3);
    tick();
    clr_clients();
    chk("t5_not_yet", {31'd0, cfg_grant}, 32'd1);
    g_q.push_back(2'b00);
    tick();
    chk("t5_preempt", {31'd0, cfg_grant}, 32'd0);
    g_q.push_back(2'b01);
    tick();
    chk("t5_dma_grant", {31'd0, dma_grant}, 32'd1);

    // Asynchronous reset mid-burst
    dma_if.tx_write = 1'b1; dma_if.tx_wdata = 8'h77; tx_q.push_back(8'h77);
    tick();
    dma_if.tx_wdata = 8'h78; tx_q.push_back(8'h78);
    tick();
    dma_if.tx_wdata = 8'h79; g_q.push_back(2'b00);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_dma_grant_async", {31'd0, dma_grant}, 32'd0);
    chk("t6_dev_strobes_async", {30'd0, dev_if.rx_read, dev_if.tx_write}, 32'd0);
    chk("t6_dma_tx_full", {31'd0, dma_if.tx_full}, 32'd1);
    clr_clients();
    tick();
    reset_n = 1'b1; g_q.push_back(2'b10);
    tick();
    chk("t6_cfg_first", {30'd0, cfg_grant, dma_grant}, 32'd2);
    cfg_req = 1'b0; dma_req = 1'b0; g_q.push_back(2'b00);
    tick(); tick();
    g_q.push_back(2'b01);
    tick(); tick();

    chk("rx_q_drained", rx_q.size(), 32'd0);
    chk("tx_q_drained", tx_q.size(), 32'd0);
    chk("g_q_pending", g_q.size(), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
